// File: rtl/mac_term_scheduler.sv
// mac_term_scheduler: round-robin arbiter and term sequencer for the shared constant/function/accumulator datapath.
// Optional stall input is compiled in with `define SEQ_STALL_EN.
module mac_term_scheduler #(
   parameter int NUM_TERMS = 6,
   parameter int SEL_W     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic             abort,
`ifdef SEQ_STALL_EN
   input  logic             stall,
`endif
   output logic [1:0]       gnt,
   output logic             ch_sel,
   output logic             busy,
   output logic [SEL_W-1:0] sel_const,
   output logic [1:0]       sel_fun,
   output logic             sel_acum,
   output logic             acc_en,
   output logic [1:0]       done
);
   localparam int CW = $clog2(NUM_TERMS);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ch_q, ch_d, rr_q, rr_d;
   logic          stall_w, win, last;
`ifdef SEQ_STALL_EN
   assign stall_w = stall;
`else
   assign stall_w = 1'b0;
`endif
   // on a tie the channel that did not win last time goes first
   assign win  = (req == 2'b11) ? ~rr_q : req[1];
   assign last = cnt_q == CW'(NUM_TERMS - 1);
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ch_d      = ch_q;
      rr_d      = rr_q;
      gnt       = '0;
      ch_sel    = 1'b0;
      busy      = 1'b0;
      sel_const = '0;
      sel_fun   = '0;
      sel_acum  = 1'b0;
      acc_en    = 1'b0;
      done      = '0;
      case (state_q)
         IDLE: if (rst_n && |req) begin
            gnt[win] = 1'b1;
            ch_d     = win;
            rr_d     = win;
            cnt_d    = '0;
            state_d  = RUN;
         end
         RUN: begin
            busy      = 1'b1;
            ch_sel    = ch_q;
            sel_const = SEL_W'(cnt_q);
            sel_fun   = 2'(32'(cnt_q) % 3);
            sel_acum  = |cnt_q;
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!stall_w) begin
               acc_en  = 1'b1;
               cnt_d   = last ? '0 : cnt_q + CW'(1);
               state_d = last ? DONE : RUN;
            end
         end
         DONE: begin
            busy       = 1'b1;
            ch_sel     = ch_q;
            done[ch_q] = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ch_q    <= 1'b0;
         rr_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         rr_q    <= rr_d;
      end
endmodule

// File: tb/tb_mac_term_scheduler.sv
// tb_mac_term_scheduler: table vectors, directed corner sequences and random stimulus against a job-level reference model.
module tb_mac_term_scheduler;
   localparam int N = 6;
   logic       clk = 0;
   logic       rst_n = 0;
   logic [1:0] req = 0;
   logic       abort = 0;
   logic       stall = 0;
   logic [1:0] gnt, sel_fun, done;
   logic       ch_sel, busy, sel_acum, acc_en;
   logic [2:0] sel_const;
   int total = 0, bad = 0;
   int acc_cnt = 0, done_cnt = 0, g1_cnt = 0;
   int m_pos = -1, m_ch = 0, m_ptr = 1;
   logic [1:0] c_gnt, c_done;
   logic       c_busy, c_acc;
   logic [2:0] c_sc;

   mac_term_scheduler #(.NUM_TERMS(N), .SEL_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .abort(abort),
`ifdef SEQ_STALL_EN
      .stall(stall),
`endif
      .gnt(gnt), .ch_sel(ch_sel), .busy(busy), .sel_const(sel_const), .sel_fun(sel_fun),
      .sel_acum(sel_acum), .acc_en(acc_en), .done(done));

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic       abort;
      logic [1:0] gnt;
      logic       busy;
      logic [2:0] sc;
      logic [1:0] sf;
      logic       sa;
      logic       ae;
      logic [1:0] dn;
   } vec_t;
   vec_t tv[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [12:0] all_out();
      return {gnt, ch_sel, busy, sel_const, sel_fun, sel_acum, acc_en, done};
   endfunction

   // expected outputs follow from the job position: -1 idle, 0..N-1 term index, N completion cycle
   task automatic model_step();
      logic [1:0] eg, ed;
      logic eb, ecs, esa, eae;
      logic [2:0] esc;
      logic [1:0] esf;
      int w;
      eg = 0; ed = 0; eb = 0; ecs = 0; esa = 0; eae = 0; esc = 0; esf = 0;
      if (!rst_n) begin
         m_pos = -1; m_ptr = 1; m_ch = 0;
      end else if (m_pos < 0) begin
         if (req != 0) begin
            w = (req == 2'b11) ? 1 - m_ptr : (req[1] ? 1 : 0);
            eg = 2'(1 << w);
            m_ch = w; m_ptr = w; m_pos = 0;
         end
      end else if (m_pos < N) begin
         eb = 1; ecs = 1'(m_ch); esc = 3'(m_pos); esf = 2'(m_pos % 3); esa = m_pos != 0;
         if (abort) m_pos = -1;
         else if (!stall) begin
            eae = 1; m_pos++;
         end
      end else begin
         eb = 1; ecs = 1'(m_ch); ed = 2'(1 << m_ch); m_pos = -1;
      end
      chk("gnt", 32'(gnt), 32'(eg));
      chk("ch_sel", 32'(ch_sel), 32'(ecs));
      chk("busy", 32'(busy), 32'(eb));
      chk("sel_const", 32'(sel_const), 32'(esc));
      chk("sel_fun", 32'(sel_fun), 32'(esf));
      chk("sel_acum", 32'(sel_acum), 32'(esa));
      chk("acc_en", 32'(acc_en), 32'(eae));
      chk("done", 32'(done), 32'(ed));
   endtask

   task automatic cyc();
      @(negedge clk);
      c_gnt = gnt; c_done = done; c_busy = busy; c_acc = acc_en; c_sc = sel_const;
      acc_cnt += int'(acc_en);
      done_cnt += int'(|done);
      g1_cnt += int'(gnt[1]);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0; req = 0; abort = 0; stall = 0;
      cyc();
      chk("reset_outputs", 32'(all_out()), 0);
      cyc();
      rst_n = 1;
   endtask

   initial begin
      tv[0] = '{2'b01, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00};
      tv[1] = '{2'b00, 0, 2'b00, 1, 0, 0, 0, 1, 2'b00};
      tv[2] = '{2'b00, 0, 2'b00, 1, 1, 1, 1, 1, 2'b00};
      tv[3] = '{2'b00, 0, 2'b00, 1, 2, 2, 1, 1, 2'b00};
      tv[4] = '{2'b00, 0, 2'b00, 1, 3, 0, 1, 1, 2'b00};
      tv[5] = '{2'b00, 0, 2'b00, 1, 4, 1, 1, 1, 2'b00};
      tv[6] = '{2'b00, 0, 2'b00, 1, 5, 2, 1, 1, 2'b00};
      tv[7] = '{2'b00, 0, 2'b00, 1, 0, 0, 0, 0, 2'b01};
      tv[8] = '{2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00};
      #1;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         req = tv[i].req; abort = tv[i].abort;
         @(negedge clk);
         chk($sformatf("tv%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
         chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
         chk($sformatf("tv%0d_sc", i), 32'(sel_const), 32'(tv[i].sc));
         chk($sformatf("tv%0d_sf", i), 32'(sel_fun), 32'(tv[i].sf));
         chk($sformatf("tv%0d_sa", i), 32'(sel_acum), 32'(tv[i].sa));
         chk($sformatf("tv%0d_ae", i), 32'(acc_en), 32'(tv[i].ae));
         chk($sformatf("tv%0d_dn", i), 32'(done), 32'(tv[i].dn));
         @(posedge clk);
         #1;
         m_pos = m_pos; // model is re-synchronised below by the reset
      end
      // tie held: ch0 first, ch1 at T+8 done at T+15, ch0 again at T+16
      do_reset();
      req = 2'b11;
      for (int k = 0; k <= 16; k++) begin
         cyc();
         if (k == 0) chk("tie_first_gnt", 32'(c_gnt), 32'(2'b01));
         if (k == 8) chk("tie_second_gnt", 32'(c_gnt), 32'(2'b10));
         if (k == 15) chk("tie_second_done", 32'(c_done), 32'(2'b10));
         if (k == 16) chk("tie_third_gnt", 32'(c_gnt), 32'(2'b01));
      end
      req = 0;
      repeat (8) cyc();
      // abort while sel_const=2
      do_reset();
      acc_cnt = 0; done_cnt = 0;
      req = 2'b01; cyc(); req = 0;
      cyc(); cyc();
      abort = 1; cyc();
      chk("abort_sc", 32'(c_sc), 2);
      chk("abort_acc_en", 32'(c_acc), 0);
      abort = 0; cyc();
      chk("abort_idle_busy", 32'(c_busy), 0);
      repeat (3) cyc();
      chk("abort_acc_pulses", 32'(acc_cnt), 2);
      chk("abort_no_done", 32'(done_cnt), 0);
      // withdrawn request while busy
      g1_cnt = 0; done_cnt = 0;
      req = 2'b01; cyc(); req = 0;
      cyc(); cyc();
      req = 2'b10; cyc(); req = 0;
      repeat (8) cyc();
      chk("withdrawn_no_gnt", 32'(g1_cnt), 0);
      chk("withdrawn_one_done", 32'(done_cnt), 1);
      // asynchronous reset mid-job
      do_reset();
      req = 2'b11; cyc(); req = 0;
      repeat (4) cyc();
      #1;
      chk("pre_reset_sc", 32'(sel_const), 4);
      rst_n = 0;
      #1;
      chk("async_reset_outputs", 32'(all_out()), 0);
      m_pos = -1; m_ptr = 1; m_ch = 0;
      cyc();
      rst_n = 1; req = 2'b11; cyc();
      chk("post_reset_gnt", 32'(c_gnt), 32'(2'b01));
      req = 0;
      repeat (8) cyc();
`ifdef SEQ_STALL_EN
      do_reset();
      acc_cnt = 0;
      req = 2'b01; cyc(); req = 0;
      repeat (3) cyc();
      stall = 1;
      for (int s = 0; s < 2; s++) begin
         cyc();
         chk("stall_sc_hold", 32'(c_sc), 3);
         chk("stall_acc_en", 32'(c_acc), 0);
      end
      stall = 0;
      repeat (3) cyc();
      cyc();
      chk("stall_done_late", 32'(c_done), 32'(2'b01));
      chk("stall_acc_pulses", 32'(acc_cnt), 6);
`endif
      do_reset();
      for (int r = 0; r < 800; r++) begin
         req = 2'($urandom_range(0, 3));
         abort = ($urandom_range(0, 11) == 0);
`ifdef SEQ_STALL_EN
         stall = ($urandom_range(0, 4) == 0);
`endif
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
